// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and defaults for the FIFO word serializer.
package fifo_word_serializer_pkg;

  // FSM encoding shared by the top-level controller and anything observing it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_OUT_WIDTH  = 8;

  // Width of a counter that indexes BEATS beats (at least one bit).
  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_shifter.sv
// Word shifter: parallel-loads one FIFO word, presents it one OUT_WIDTH beat at
// a time (MSB or LSB first) and flags the final beat of the word.
module fifo_word_serializer_shifter
  import fifo_word_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [OUT_WIDTH-1:0]  beat_o,
  output logic                  last_o
);

  localparam int unsigned BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned CW    = beat_cnt_width(BEATS);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(BEATS - 1));

  // The beat on the wire is always the slice that leaves the register next.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign beat_o = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
  end else begin : g_lsb_first
    assign beat_o = shift_q[OUT_WIDTH-1:0];
  end

  // Next-state: load a fresh word, or advance one beat on each accepted handshake.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = (MSB_FIRST != 0) ? (shift_q << OUT_WIDTH) : (shift_q >> OUT_WIDTH);
      // Return to zero explicitly after the last beat rather than relying on wrap,
      // so BEATS need not be a power of two.
      cnt_d   = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// FIFO drain stage: pops DATA_WIDTH words from a 1-cycle-latency FIFO and emits
// each as DATA_WIDTH/OUT_WIDTH beats on a valid/ready stream. DATA_WIDTH must be
// a multiple of OUT_WIDTH with at least two beats per word.
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dataout,
  output logic                  fifo_rd_en,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;
  logic                 beat_last;
  logic                 handshake;
  logic                 last_hs;

  // All stream outputs decode registered state, so they are glitch-free and
  // remain stable while the sink stalls.
  assign out_valid = (state_q == S_SEND);
  assign out_last  = out_valid && beat_last;
  assign busy      = (state_q != S_IDLE);
  assign word_cnt  = word_cnt_q;

  assign handshake = out_valid && out_ready;
  assign last_hs   = handshake && beat_last;

  // Pop when idle, or prefetch on the accepted last beat; never on an empty FIFO
  // and never during reset, so at most one word is ever in flight.
  assign fifo_rd_en = !rst && !fifo_empty && ((state_q == S_IDLE) || last_hs);

  fifo_word_serializer_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (state_q == S_LOAD),
    .shift_i (handshake),
    .data_i  (fifo_dataout),
    .beat_o  (out_data),
    .last_o  (beat_last)
  );

  // Controller FSM and completed-word statistics counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (!fifo_empty) state_q <= S_LOAD;
        // FIFO read data is valid this cycle; the shifter captures it.
        S_LOAD: state_q <= S_SEND;
        S_SEND: begin
          if (last_hs) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            state_q    <= fifo_empty ? S_IDLE : S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Self-checking bench for fifo_word_serializer: behavioural 1-cycle-latency FIFO,
// table of words with hand-written expected beats, scoreboard of beats.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;

  // MSB-first instance
  logic        fifo_empty, fifo_rd_en;
  logic [31:0] fifo_dataout;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy;
  logic [15:0] word_cnt;

  // LSB-first instance
  logic        fifo_empty_l, fifo_rd_en_l;
  logic [31:0] fifo_dataout_l;
  logic [7:0]  out_data_l;
  logic        out_valid_l, out_last_l, busy_l;
  logic [15:0] word_cnt_l;

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .word_cnt(word_cnt));

  fifo_word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) dut_l (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_l), .fifo_dataout(fifo_dataout_l),
    .fifo_rd_en(fifo_rd_en_l), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l), .word_cnt(word_cnt_l));

  typedef struct {
    logic [31:0]      word;
    logic [0:3][7:0]  msb;   // expected beats, emission order, MSB_FIRST=1
    logic [0:3][7:0]  lsb;   // expected beats, emission order, MSB_FIRST=0
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  vec_t  vecs [7];
  beat_t exp_q[$];
  beat_t exp_l_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFOs with 1-cycle read latency
  logic [31:0] mem   [64];
  logic [31:0] mem_l [64];
  logic [5:0]  wr_ptr = '0, rd_ptr = '0, wr_ptr_l = '0, rd_ptr_l = '0;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_empty_l = (wr_ptr_l == rd_ptr_l);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dataout <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 6'd1;
    end
    if (fifo_rd_en_l) begin
      fifo_dataout_l <= mem_l[rd_ptr_l];
      rd_ptr_l       <= rd_ptr_l + 6'd1;
    end
  end

  task automatic push_word(input int idx);
    mem[wr_ptr] = vecs[idx].word;
    wr_ptr      = wr_ptr + 6'd1;
    for (int b = 0; b < 4; b++) exp_q.push_back('{vecs[idx].msb[b], (b == 3)});
  endtask

  task automatic push_word_l(input int idx);
    mem_l[wr_ptr_l] = vecs[idx].word;
    wr_ptr_l        = wr_ptr_l + 6'd1;
    for (int b = 0; b < 4; b++) exp_l_q.push_back('{vecs[idx].lsb[b], (b == 3)});
  endtask

  // Monitor: scoreboard, stall stability, underflow and event counters
  int   cyc = 0;
  int   rd_cyc = 0, last_hs_cyc = 0, n_rd = 0, n_last = 0, n_beats = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      n_rd   <= n_rd + 1;
      rd_cyc <= cyc;
      check("no_underflow", 64'(fifo_empty), 64'(0));
    end
    if (fifo_rd_en_l) check("no_underflow_l", 64'(fifo_empty_l), 64'(0));
    if (prev_stall && !rst) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(out_data), 64'(prev_data));
      check("hold_last", 64'(out_last), 64'(prev_last));
    end
    if (out_valid && out_ready && !rst) begin
      n_beats <= n_beats + 1;
      if (out_last) begin
        n_last      <= n_last + 1;
        last_hs_cyc <= cyc;
      end
      check("sb_has_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("beat_data", 64'(out_data), 64'(exp_q[0].data));
        check("beat_last", 64'(out_last), 64'(exp_q[0].last));
        void'(exp_q.pop_front());
      end
    end
    if (out_valid_l && out_ready && !rst) begin
      check("sb_has_expected_l", 64'(exp_l_q.size() != 0), 64'(1));
      if (exp_l_q.size() != 0) begin
        check("beat_data_l", 64'(out_data_l), 64'(exp_l_q[0].data));
        check("beat_last_l", 64'(out_last_l), 64'(exp_l_q[0].last));
        void'(exp_l_q.pop_front());
      end
    end
    prev_stall <= out_valid && !out_ready && !rst;
    prev_data  <= out_data;
    prev_last  <= out_last;
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(out_valid), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(busy || exp_q.size() != 0), 64'(0));
  endtask

  int b_rd, b_last, b_beats, b_cnt, n;
  logic pat [7];

  initial begin
    vecs[0] = '{32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}, {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[1] = '{32'hA1B2C3D4, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, {8'hD4, 8'hC3, 8'hB2, 8'hA1}};
    vecs[2] = '{32'd34,       {8'h00, 8'h00, 8'h00, 8'h22}, {8'h22, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{32'd100,      {8'h00, 8'h00, 8'h00, 8'h64}, {8'h64, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{32'd1,        {8'h00, 8'h00, 8'h00, 8'h01}, {8'h01, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, {8'hEF, 8'hBE, 8'hAD, 8'hDE}};
    vecs[6] = '{32'hCAFEF00D, {8'hCA, 8'hFE, 8'hF0, 8'h0D}, {8'h0D, 8'hF0, 8'hFE, 8'hCA}};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held 3 cycles with a non-empty FIFO
    rst       = 1'b1;
    out_ready = 1'b1;
    push_word(0);
    push_word_l(0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
      check("rst_rd_en_l", 64'(fifo_rd_en_l), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_word_cnt", 64'(word_cnt), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
    end
    rst = 1'b0;

    // Single word, both beat orders, latency 2 from rd_en
    wait_valid("t2_valid");
    check("t2_latency", 64'(cyc - rd_cyc), 64'(2));
    wait_idle("t2_idle");
    repeat (2) @(posedge clk);
    #1;
    check("t2_word_cnt", 64'(word_cnt), 64'(1));
    check("t2_rd_pulses", 64'(n_rd), 64'(1));
    check("t2_last_pulses", 64'(n_last), 64'(1));
    check("t2_beats", 64'(n_beats), 64'(4));
    check("t2_word_cnt_l", 64'(word_cnt_l), 64'(1));
    check("t2_sb_l_empty", 64'(exp_l_q.size()), 64'(0));
    check("t2_busy_l", 64'(busy_l), 64'(0));

    // Back-pressure pattern on one word
    out_ready = 1'b0;
    b_beats   = n_beats;
    push_word(1);
    wait_valid("t3_valid");
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    check("t3_beats", 64'(n_beats - b_beats), 64'(4));
    check("t3_sb_empty", 64'(exp_q.size()), 64'(0));
    out_ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_word_cnt", 64'(word_cnt), 64'(2));

    // Three preloaded words: prefetch and one bubble between words
    b_rd = n_rd; b_last = n_last; b_beats = n_beats; b_cnt = int'(word_cnt);
    push_word(2);
    push_word(3);
    push_word(4);
    wait_valid("t4_valid");
    n = cyc;
    for (int i = 0; i < 60 && n_last < b_last + 3; i++) begin
      @(posedge clk); #1;
    end
    check("t4_last_pulses", 64'(n_last - b_last), 64'(3));
    check("t4_span", 64'(last_hs_cyc - n), 64'(13));
    wait_idle("t4_idle");
    check("t4_rd_pulses", 64'(n_rd - b_rd), 64'(3));
    check("t4_beats", 64'(n_beats - b_beats), 64'(12));
    check("t4_word_cnt", 64'(int'(word_cnt) - b_cnt), 64'(3));

    // FIFO empty window, then refill
    b_rd = n_rd;
    push_word(0);
    wait_idle("t5_idle1");
    repeat (10) begin
      @(posedge clk); #1;
      check("t5_no_rd", 64'(fifo_rd_en), 64'(0));
      check("t5_idle", 64'(busy), 64'(0));
    end
    check("t5_rd_pulses", 64'(n_rd - b_rd), 64'(1));
    push_word(1);
    wait_valid("t5_valid");
    check("t5_latency", 64'(cyc - rd_cyc), 64'(2));
    wait_idle("t5_idle2");
    check("t5_word_cnt", 64'(word_cnt), 64'(7));

    // Reset after two beats of a word
    out_ready = 1'b0;
    push_word(5);
    wait_valid("t6_valid");
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b1;
    out_ready = 1'b0;
    check("t6_partial_left", 64'(exp_q.size()), 64'(2));
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    push_word(6);
    b_rd = n_rd;
    @(posedge clk); #1;
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_word_cnt", 64'(word_cnt), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    repeat (2) begin
      check("t6_rd_en_in_rst", 64'(fifo_rd_en), 64'(0));
      @(posedge clk); #1;
    end
    check("t6_rd_pulses_in_rst", 64'(n_rd - b_rd), 64'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    wait_valid("t6_valid2");
    check("t6_latency", 64'(cyc - rd_cyc), 64'(2));
    wait_idle("t6_idle");
    check("t6_word_cnt_after", 64'(word_cnt), 64'(1));

    check("final_sb_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
